// File: rtl/heater_thermostat_if.sv
// Bundles the sensor-sample, control and status signals of the heater thermostat.
//   master : sensor/control side (drives temp_in, temp_valid, setpoint, enable, fault_clr)
//   slave  : thermostat side (drives heater_en, filt_temp, fault, state_led)
interface heater_thermostat_if;
  logic [15:0] temp_in;     // raw signed temperature, 1/16 degC per LSB
  logic        temp_valid;  // one-cycle strobe qualifying temp_in
  logic [15:0] setpoint;    // signed target temperature, 1/16 degC
  logic        enable;      // low forces the heater off
  logic        fault_clr;   // one-cycle pulse, leaves FAULT
  logic        heater_en;   // registered heater drive
  logic [15:0] filt_temp;   // registered 4-sample average
  logic        fault;       // high exactly while in FAULT
  logic [3:0]  state_led;   // one-hot {FAULT, ON, OFF, IDLE}

  modport master (
    output temp_in, temp_valid, setpoint, enable, fault_clr,
    input  heater_en, filt_temp, fault, state_led
  );

  modport slave (
    input  temp_in, temp_valid, setpoint, enable, fault_clr,
    output heater_en, filt_temp, fault, state_led
  );
endinterface

// File: rtl/heater_thermostat.sv
// Hysteresis heater thermostat fed by raw DS18B20 temperature words.
// Validates each sample, smooths it with a 4-sample moving average, and drives the heater
// through an IDLE/OFF/ON/FAULT FSM with minimum dwell, over-temperature cutoff and a
// sensor-fault watchdog.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of heater_thermostat_if (samples/controls in, heater/status out)
module heater_thermostat #(
  parameter logic signed [15:0] HYST      = 16'sd32,
  parameter logic signed [15:0] MAX_TEMP  = 16'sd1440,
  parameter logic [27:0]        MIN_DWELL = 28'd135000000,
  parameter logic [27:0]        TIMEOUT   = 28'd81000000,
  parameter logic [1:0]         BAD_LIMIT = 2'd3
) (
  input logic                clk,
  input logic                rst_n,
  heater_thermostat_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StOff, StOn, StFault} state_e;

  state_e              state_q, state_d;
  logic [3:0][15:0]    samp_q, samp_d;   // [0] newest, [3] oldest
  logic signed [17:0]  sum_q, sum_d;
  logic [15:0]         filt_q, filt_d;
  logic [27:0]         dwell_q, dwell_d;
  logic [27:0]         wdog_q, wdog_d;
  logic [1:0]          bad_q, bad_d;
  logic                heater_q, heater_d;
  logic                fault_q, fault_d;
  logic [3:0]          led_q, led_d;

  logic signed [15:0]  temp_s;
  logic                sample_ok, accept, reject, in_fault, fault_hit, dwell_done;
  logic signed [16:0]  filt_x, sp_x, lo_x, hi_x, max_x;
  logic                active_d;

  always_comb begin
    temp_s    = $signed(bus.temp_in);
    // 0x0550 is the DS18B20 power-on value: the sensor never actually converted.
    sample_ok = (bus.temp_in != 16'h0550) && (temp_s >= -16'sd880) && (temp_s <= 16'sd2000);
    in_fault  = (state_q == StFault);
    accept    = bus.temp_valid && !in_fault && sample_ok;
    reject    = bus.temp_valid && !in_fault && !sample_ok;

    // 17-bit thresholds so extreme setpoints cannot wrap.
    filt_x = $signed({filt_q[15], filt_q});
    sp_x   = $signed({bus.setpoint[15], bus.setpoint});
    lo_x   = sp_x - $signed({HYST[15], HYST});
    hi_x   = sp_x + $signed({HYST[15], HYST});
    max_x  = $signed({MAX_TEMP[15], MAX_TEMP});

    dwell_done = (dwell_q == MIN_DWELL);
    fault_hit  = (bad_q == BAD_LIMIT) || (wdog_q == TIMEOUT);

    // Next state; fault entry outranks forced-off, which outranks the hysteresis toggle.
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fault_hit)   state_d = StFault;
        else if (accept) state_d = StOff;
      end
      StOff: begin
        if (fault_hit) begin
          state_d = StFault;
        end else if (bus.enable && (filt_x < lo_x) && (filt_x < max_x) && dwell_done) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (fault_hit)                             state_d = StFault;
        else if (!bus.enable || (filt_x >= max_x)) state_d = StOff;
        else if ((filt_x >= hi_x) && dwell_done)   state_d = StOff;
      end
      StFault: begin
        if (bus.fault_clr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    active_d = (state_d == StOff) || (state_d == StOn);

    // Moving-average buffer: the first sample after IDLE primes every slot.
    samp_d = samp_q;
    sum_d  = sum_q;
    filt_d = filt_q;
    if (accept) begin
      if (state_q == StIdle) begin
        samp_d = {4{bus.temp_in}};
        sum_d  = $signed({bus.temp_in, 2'b00});
      end else begin
        samp_d = {samp_q[2:0], bus.temp_in};
        sum_d  = sum_q - $signed({{2{samp_q[3][15]}}, samp_q[3]})
                       + $signed({{2{bus.temp_in[15]}}, bus.temp_in});
      end
      // sum >>> 2 truncated to 16 bits.
      filt_d = sum_d[17:2];
    end

    // Consecutive-reject counter, frozen in FAULT until cleared.
    bad_d = bad_q;
    if (in_fault) begin
      if (bus.fault_clr) bad_d = '0;
    end else if (accept) begin
      bad_d = '0;
    end else if (reject && (bad_q != BAD_LIMIT)) begin
      bad_d = bad_q + 2'd1;
    end

    // Watchdog runs only while regulating.
    if (active_d && !accept) wdog_d = (wdog_q == TIMEOUT) ? wdog_q : wdog_q + 28'd1;
    else                     wdog_d = '0;

    // Dwell preloaded on leaving IDLE so the first ON decision is not delayed.
    if ((state_q == StIdle) && (state_d == StOff)) begin
      dwell_d = MIN_DWELL;
    end else if (((state_q == StOff) && (state_d == StOn)) ||
                 ((state_q == StOn) && (state_d == StOff))) begin
      dwell_d = '0;
    end else if (active_d) begin
      dwell_d = (dwell_q == MIN_DWELL) ? dwell_q : dwell_q + 28'd1;
    end else begin
      dwell_d = '0;
    end

    heater_d = (state_d == StOn);
    fault_d  = (state_d == StFault);
    led_d    = 4'b0001 << state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      samp_q   <= '0;
      sum_q    <= '0;
      filt_q   <= '0;
      dwell_q  <= '0;
      wdog_q   <= '0;
      bad_q    <= '0;
      heater_q <= 1'b0;
      fault_q  <= 1'b0;
      led_q    <= 4'b0001;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      sum_q    <= sum_d;
      filt_q   <= filt_d;
      dwell_q  <= dwell_d;
      wdog_q   <= wdog_d;
      bad_q    <= bad_d;
      heater_q <= heater_d;
      fault_q  <= fault_d;
      led_q    <= led_d;
    end
  end

  assign bus.heater_en = heater_q;
  assign bus.filt_temp = filt_q;
  assign bus.fault     = fault_q;
  assign bus.state_led = led_q;

endmodule

// File: tb/tb_heater_thermostat.sv
// Self-checking bench for heater_thermostat: directed scenarios plus randomized traffic,
// all compared every cycle against a behavioural thermostat model.
module tb_heater_thermostat;
  localparam int MinDwell = 100;
  localparam int Timeout  = 1000;
  localparam int MIdle = 0, MOff = 1, MOn = 2, MFault = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  heater_thermostat_if th_if ();

  heater_thermostat #(
    .HYST      (16'sd32),
    .MAX_TEMP  (16'sd1440),
    .MIN_DWELL (28'd100),
    .TIMEOUT   (28'd1000),
    .BAD_LIMIT (2'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (th_if.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: mode, sample window (newest first), average, counters.
  int m_mode, m_filt, m_dwell, m_wd, m_bad;
  int m_win[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_div4(input int s);
    return (s >= 0) ? s / 4 : -((-s + 3) / 4);
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_filt = 0; m_dwell = 0; m_wd = 0; m_bad = 0;
    for (int i = 0; i < 4; i++) m_win[i] = 0;
  endtask

  // One clock edge of the thermostat rules, using the inputs held across that edge.
  task automatic model_step();
    int t, sp, nm, sum;
    bit acc, rej, flt;
    t   = int'($signed(th_if.temp_in));
    sp  = int'($signed(th_if.setpoint));
    flt = (m_mode == MFault);
    acc = th_if.temp_valid && !flt && (t != 1360) && (t >= -880) && (t <= 2000);
    rej = th_if.temp_valid && !flt && !acc;
    nm  = m_mode;
    if (flt) begin
      if (th_if.fault_clr) nm = MIdle;
    end else if (m_bad >= 3 || m_wd >= Timeout) begin
      nm = MFault;
    end else if (m_mode == MIdle) begin
      if (acc) nm = MOff;
    end else if (m_mode == MOff) begin
      if (th_if.enable && m_filt < sp - 32 && m_filt < 1440 && m_dwell >= MinDwell) nm = MOn;
    end else begin
      if (!th_if.enable || m_filt >= 1440) nm = MOff;
      else if (m_filt >= sp + 32 && m_dwell >= MinDwell) nm = MOff;
    end
    if (acc) begin
      if (m_mode == MIdle) begin
        for (int i = 0; i < 4; i++) m_win[i] = t;
      end else begin
        for (int i = 3; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = t;
      end
      sum = m_win[0] + m_win[1] + m_win[2] + m_win[3];
      m_filt = floor_div4(sum);
    end
    if (flt) begin
      if (th_if.fault_clr) m_bad = 0;
    end else if (acc) m_bad = 0;
    else if (rej && m_bad < 3) m_bad++;
    if ((nm == MOff || nm == MOn) && !acc) m_wd = (m_wd < Timeout) ? m_wd + 1 : m_wd;
    else m_wd = 0;
    if (m_mode == MIdle && nm == MOff) m_dwell = MinDwell;
    else if ((m_mode == MOff && nm == MOn) || (m_mode == MOn && nm == MOff)) m_dwell = 0;
    else if (nm == MOff || nm == MOn) m_dwell = (m_dwell < MinDwell) ? m_dwell + 1 : m_dwell;
    else m_dwell = 0;
    m_mode = nm;
  endtask

  task automatic compare_all();
    check_eq("heater_en", {31'd0, th_if.heater_en}, {31'd0, m_mode == MOn});
    check_eq("fault", {31'd0, th_if.fault}, {31'd0, m_mode == MFault});
    check_eq("state_led", {28'd0, th_if.state_led}, 32'd1 << m_mode);
    check_eq("filt_temp", {16'd0, th_if.filt_temp}, {16'd0, m_filt[15:0]});
  endtask

  // Advance one cycle; returns at the following falling edge with outputs checked.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] v);
    th_if.temp_in = v;
    th_if.temp_valid = 1'b1;
    tick();
    th_if.temp_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    th_if.fault_clr = 1'b1;
    tick();
    th_if.fault_clr = 1'b0;
  endtask

  initial begin
    int r, v;
    th_if.temp_in = '0; th_if.temp_valid = 1'b0; th_if.setpoint = 16'h0320;
    th_if.enable = 1'b1; th_if.fault_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_led", {28'd0, th_if.state_led}, 32'h1);
    check_eq("reset_heater", {31'd0, th_if.heater_en}, 32'h0);
    check_eq("reset_filt", {16'd0, th_if.filt_temp}, 32'h0);
    rst_n = 1'b1;
    ticks(3);

    // Cold start: average primed at +1, heater on at +2.
    send(16'h0190);
    check_eq("cold_filt", {16'd0, th_if.filt_temp}, 32'h0190);
    tick();
    check_eq("cold_heater", {31'd0, th_if.heater_en}, 32'h1);

    // Hysteresis upper crossing.
    for (int i = 0; i < 4; i++) begin
      send(16'h0340);
      if (i == 2) begin
        check_eq("hyst_filt3", {16'd0, th_if.filt_temp}, 32'd724);
        check_eq("hyst_on3", {31'd0, th_if.heater_en}, 32'h1);
      end
      if (i < 3) ticks(109);
    end
    check_eq("hyst_filt4", {16'd0, th_if.filt_temp}, 32'h0340);
    tick();
    check_eq("hyst_off", {31'd0, th_if.heater_en}, 32'h0);

    // Dwell: cold samples right after turning off; model checks the exact turn-on cycle.
    for (int i = 0; i < 4; i++) send(16'h0190);
    ticks(110);
    check_eq("dwell_on", {31'd0, th_if.heater_en}, 32'h1);

    // Over-temperature cutoff ignores dwell.
    th_if.setpoint = 16'h0640;
    ticks(5);
    for (int i = 0; i < 4; i++) send(16'h05B0);
    check_eq("ot_filt", {16'd0, th_if.filt_temp}, 32'h05B0);
    tick();
    check_eq("ot_off", {31'd0, th_if.heater_en}, 32'h0);
    ticks(10);

    // Sensor fault from three power-on words, then recovery.
    for (int i = 0; i < 3; i++) send(16'h0550);
    ticks(2);
    check_eq("sf_fault", {31'd0, th_if.fault}, 32'h1);
    check_eq("sf_led", {28'd0, th_if.state_led}, 32'h8);
    pulse_clr();
    check_eq("sf_clr_led", {28'd0, th_if.state_led}, 32'h1);
    send(16'h0190);
    check_eq("sf_off_led", {28'd0, th_if.state_led}, 32'h2);
    tick();
    check_eq("sf_on_led", {28'd0, th_if.state_led}, 32'h4);

    // Watchdog timeout while ON.
    ticks(1002);
    check_eq("to_fault", {31'd0, th_if.fault}, 32'h1);
    pulse_clr();

    // Asynchronous reset mid-ON.
    send(16'h0190);
    tick();
    check_eq("pre_rst_on", {31'd0, th_if.heater_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_heater", {31'd0, th_if.heater_en}, 32'h0);
    check_eq("arst_filt", {16'd0, th_if.filt_temp}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    th_if.setpoint = 16'h0320;
    ticks(2);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      th_if.temp_valid = ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 19));
      if (r == 0)      v = 1360;
      else if (r == 1) v = -880;
      else if (r == 2) v = 2000;
      else if (r == 3) v = -881;
      else if (r == 4) v = 2001;
      else             v = int'($urandom_range(0, 2000)) - 200;
      th_if.temp_in   = v[15:0];
      th_if.fault_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) th_if.enable = ~th_if.enable;
      if ($urandom_range(0, 299) == 0) begin
        r = int'($urandom_range(0, 3));
        th_if.setpoint = (r == 0) ? 16'h0320 : (r == 1) ? 16'h0190 :
                         (r == 2) ? 16'h0640 : 16'h0000;
      end
      tick();
    end
    th_if.temp_valid = 1'b0;
    th_if.fault_clr  = 1'b0;
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/heater_thermostat.md
Name: heater_thermostat

Overview:
- Downstream consumer of the DS18B20 bus master.
- Takes each new raw 16-bit temperature word (signed, 1/16 °C per LSB) with a one-cycle valid strobe, validates it and smooths it with a 4-sample moving average.
- Drives the heater enable through a hysteresis thermostat FSM with minimum dwell times, an over-temperature cutoff and a sensor-fault watchdog.

Parameters:
- HYST, 16'sd32: hysteresis half-band (2 °C).
- MAX_TEMP, 16'sd1440: hard over-temperature cutoff (90 °C).
- MIN_DWELL, 28'd135000000: minimum cycles between heater toggles (5 s at 27 MHz).
- TIMEOUT, 28'd81000000: maximum cycles between accepted samples (3 s).
- BAD_LIMIT, 2'd3: consecutive rejected samples that cause a fault.

Ports:
- CLK  in  1  system clock (27 MHz)
- RST_N  in  1  asynchronous active-low reset
- TEMP_IN  in  16  raw signed temperature word from the sensor stage
- TEMP_VALID  in  1  one-cycle strobe; TEMP_IN is valid on this cycle
- SETPOINT  in  16  signed target temperature, 1/16 °C
- ENABLE  in  1  thermostat enable; low forces the heater off
- FAULT_CLR  in  1  one-cycle pulse; clears FAULT
- HEATER_EN  out  1  registered heater drive
- FILT_TEMP  out  16  registered averaged temperature
- FAULT  out  1  sensor/timeout fault flag
- STATE_LED  out  4  one-hot state: {FAULT, ON, OFF, IDLE}

Behaviour:
- Reset (async, RST_N low):
  - state IDLE; HEATER_EN 0; FILT_TEMP 0; FAULT 0; STATE_LED 4'b0001.
  - All counters and the sample buffer cleared.
- Sample acceptance (on TEMP_VALID):
  - Reject if TEMP_IN == 16'h0550 (DS18B20 power-on value), TEMP_IN < -880 or TEMP_IN > 2000 (signed).
  - A reject increments the bad counter. An accept clears the bad counter and the watchdog counter.
  - TEMP_VALID is ignored in FAULT.
- Filter:
  - 4-entry shift buffer; sum held at 18-bit signed; FILT_TEMP = sum >>> 2 (arithmetic, truncating toward −inf).
  - FILT_TEMP updates on the cycle after an accepted TEMP_VALID.
  - First accepted sample in IDLE loads all 4 entries with that sample.
- Thresholds are computed 17-bit signed (no wrap):
  - lo = SETPOINT − HYST
  - hi = SETPOINT + HYST
- Dwell counter: 28-bit, saturates at MIN_DWELL. Cleared on every OFF↔ON transition. Preloaded to MIN_DWELL on IDLE→OFF.
- Watchdog: 28-bit, counts every cycle in OFF/ON, cleared on each accepted sample. Held at 0 in IDLE and FAULT.
- FSM (evaluated every cycle on current FILT_TEMP, not only on new samples):
  - IDLE → OFF: on the first accepted sample.
  - OFF → ON: ENABLE && FILT_TEMP < lo && FILT_TEMP < MAX_TEMP && dwell == MIN_DWELL.
  - ON → OFF when either:
    - FILT_TEMP >= hi && dwell == MIN_DWELL; or
    - immediately, ignoring dwell, if !ENABLE or FILT_TEMP >= MAX_TEMP.
  - Any non-FAULT state → FAULT: bad counter reaches BAD_LIMIT, or watchdog reaches TIMEOUT.
  - FAULT → IDLE: on FAULT_CLR. This clears FAULT and all counters; the buffer is re-filled from the next accepted sample.
  - Priority when events coincide: FAULT entry > over-temp/disable off > hysteresis toggle.
  - FAULT_CLR in any other state: no effect.
- Outputs:
  - HEATER_EN is registered and equals 1 only in ON.
  - Latency: accepted TEMP_VALID at cycle n → FILT_TEMP at n+1 → HEATER_EN at n+2.
  - FAULT = 1 exactly while in the FAULT state.
- Reset mid-operation: HEATER_EN drops to 0 asynchronously and the FSM restarts in IDLE.

Test Plan:
Bench parameters: MIN_DWELL=100, TIMEOUT=1000; SETPOINT=0x0320, HYST=32, ENABLE=1 unless stated.
- Cold start: reset, one TEMP_VALID with 0x0190 → FILT_TEMP=0x0190 at +1 cycle; HEATER_EN=1 at +2 cycles (dwell preloaded).
- Hysteresis: from ON with buffer 0x0190, feed 0x0340 ×4, 110 cycles apart → after 3 samples FILT=724, heater stays on; after 4th FILT=0x0340 (832 ≥ hi) → HEATER_EN=0 two cycles later.
- Dwell: immediately after ON→OFF, feed 0x0190 ×4 back-to-back → HEATER_EN stays 0 until exactly 100 cycles after the OFF entry, then 1.
- Over-temp: SETPOINT=0x0640, in ON with dwell just cleared, feed 0x05B0 ×4 → once FILT_TEMP ≥ 1440, HEATER_EN=0 on the next cycle despite the dwell.
- Sensor fault: three consecutive TEMP_VALID with 0x0550 → FAULT=1, HEATER_EN=0, STATE_LED=4'b1000; FAULT_CLR → STATE_LED=4'b0001; next 0x0190 → OFF, then ON.
- Timeout/reset: in ON, no TEMP_VALID for 1000 cycles → FAULT=1. Separately, assert RST_N low mid-ON → HEATER_EN=0 without a clock edge, FILT_TEMP=0.
